// File: rtl/phase_sequencer.sv
// Counts micro-steps inside the current instruction-cycle phase and issues one next-phase request per phase.
// Optional HALT/HALTED ports are compiled in when STATUS_SEQ_HALT_EN is defined.

module phase_sequencer #(
    parameter int unsigned FI_STEPS  = 3,
    parameter int unsigned EXC_STEPS = 2,
    parameter int unsigned MODE_W    = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FI,
    input  logic              SRC,
    input  logic              DST,
    input  logic              EXC,
    input  logic [MODE_W-1:0] SRC_MODE,
    input  logic [MODE_W-1:0] DST_MODE,
    input  logic              MEM_WAIT,
`ifdef STATUS_SEQ_HALT_EN
    input  logic              HALT,
    output logic              HALTED,
`endif
    output logic              FI0,
    output logic              SRC0,
    output logic              DST0,
    output logic              EXC0,
    output logic [2:0]        T,
    output logic              LAST,
    output logic              ERR
);

    localparam int unsigned T_W   = 3;
    localparam int unsigned REQ_W = 4;
    localparam int unsigned R_FI  = 0;
    localparam int unsigned R_SRC = 1;
    localparam int unsigned R_DST = 2;
    localparam int unsigned R_EXC = 3;
    localparam logic [T_W-1:0] FI_LAST  = T_W'(FI_STEPS - 1);
    localparam logic [T_W-1:0] EXC_LAST = T_W'(EXC_STEPS - 1);
    localparam logic [T_W-1:0] T_MAX    = '1;

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_REQ = 2'd1,
        ST_HLT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [T_W-1:0]   t_q, t_d;
    logic [REQ_W-1:0] req_q, req_d;
    logic             err_q, err_d;
`ifdef STATUS_SEQ_HALT_EN
    logic             halted_q, halted_d;
`endif

    logic             one_hot_c;
    logic             at_end_c;
    logic [T_W-1:0]   last_c;
    logic [REQ_W-1:0] next_req_c;

    // Final step index of a mode-driven phase; mode 0 is treated as a single step so it can never stall.
    function automatic logic [T_W-1:0] mode_last(input logic [MODE_W-1:0] mode);
        logic [31:0]    m;
        logic [T_W-1:0] r;
        m = 32'(mode);
        if (m <= 32'd1)      r = T_W'(0);
        else if (m <= 32'd3) r = T_W'(1);
        else                 r = T_W'(2);
        return r;
    endfunction

    // End-step and next-phase decode for the current phase.
    always_comb begin
        one_hot_c  = $onehot({FI, SRC, DST, EXC});
        last_c     = EXC_LAST;
        next_req_c = '0;
        if (FI) begin
            last_c = FI_LAST;
            if (SRC_MODE != '0)      next_req_c[R_SRC] = 1'b1;
            else if (DST_MODE != '0) next_req_c[R_DST] = 1'b1;
            else                     next_req_c[R_EXC] = 1'b1;
        end else if (SRC) begin
            last_c = mode_last(SRC_MODE);
            if (DST_MODE != '0) next_req_c[R_DST] = 1'b1;
            else                next_req_c[R_EXC] = 1'b1;
        end else if (DST) begin
            last_c = mode_last(DST_MODE);
            next_req_c[R_EXC] = 1'b1;
        end else begin
            next_req_c[R_FI] = 1'b1;
        end
        at_end_c = one_hot_c && (t_q >= last_c);
    end

    // Next-state logic; a pending error always resolves into an FI0 request.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        req_d    = '0;
        err_d    = 1'b0;
`ifdef STATUS_SEQ_HALT_EN
        halted_d = halted_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (err_q) begin
                    state_d      = ST_REQ;
                    req_d[R_FI]  = 1'b1;
                    t_d          = '0;
                end else if (!one_hot_c) begin
                    err_d = 1'b1;
                    t_d   = '0;
                end else if (!MEM_WAIT) begin
                    if (at_end_c) begin
`ifdef STATUS_SEQ_HALT_EN
                        if (EXC && HALT) begin
                            state_d  = ST_HLT;
                            halted_d = 1'b1;
                        end else begin
                            state_d = ST_REQ;
                            req_d   = next_req_c;
                        end
`else
                        state_d = ST_REQ;
                        req_d   = next_req_c;
`endif
                    end else if (t_q != T_MAX) begin
                        t_d = t_q + T_W'(1);
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_RUN;
                t_d     = '0;
            end
`ifdef STATUS_SEQ_HALT_EN
            ST_HLT: begin
                state_d = ST_HLT;
            end
`endif
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_RUN;
            t_q      <= '0;
            req_q    <= '0;
            err_q    <= 1'b0;
`ifdef STATUS_SEQ_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            req_q    <= req_d;
            err_q    <= err_d;
`ifdef STATUS_SEQ_HALT_EN
            halted_q <= halted_d;
`endif
        end
    end

    assign {EXC0, DST0, SRC0, FI0} = req_q;
    assign T    = t_q;
    assign ERR  = err_q;
    assign LAST = !RST && (state_q == ST_RUN) && !err_q && one_hot_c && (t_q == last_c);
`ifdef STATUS_SEQ_HALT_EN
    assign HALTED = halted_q;
`endif

endmodule
